seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial pattern detector; successor to the fixed-pattern Mealy sequence detector.
- Samples one bit per qualified clock, compares the last PAT_W bits against a pattern, and pulses `match`.
- Supports overlapping and non-overlapping detection, selected at run time, plus a saturating match counter.
- Sits behind the bit-serialiser that walks a byte MSB-first, feeding the per-bit match vector.

Parameters:
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011: pattern to detect; MSB is the first bit received.
- CNT_W, 8: width of the match counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies in_bit this cycle.
- in_bit  input  1  serial data bit.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_count.
- match  output  1  registered one-cycle pulse on pattern completion.
- match_count  output  CNT_W  saturating count of matches.
- fill  output  $clog2(PAT_W+1)  debug: valid history bits held (0..PAT_W).

Behaviour:
- Reset (async, active-high): hist = 0, fill = 0, match = 0, match_count = 0; all take effect immediately, not at the next edge.
- State registers:
  - hist[PAT_W-1:0]: shift register of received bits.
  - fill: saturating count of valid bits in hist, 0..PAT_W.
- On posedge with in_valid = 1:
  - hist_n = {hist[PAT_W-2:0], in_bit}; fill_n = min(fill+1, PAT_W).
  - hit = (fill_n == PAT_W) && (hist_n == active pattern).
  - hist <= hist_n.
  - match <= hit.
  - fill <= (hit && !overlap_en) ? 0 : fill_n.
- On posedge with in_valid = 0: hist and fill hold; match <= 0.
- Latency: match is high in the cycle after the edge that sampled the completing bit. Exactly one pulse per detection; no combinational path from in_bit to match.
- Overlap mode: a suffix of a matched window may begin the next match (1011011 gives two hits for 1011).
- Non-overlap mode: after a hit, PAT_W fresh bits are required before the next hit is possible.
- overlap_en is sampled on the same edge as the bit; changing it mid-stream affects only the post-hit fill decision.
- match_count:
  - Increments on each edge where hit = 1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority over an increment on the same edge: result is 0.
- Patterns are compared bitwise. Leading zeros in PATTERN are significant once fill = PAT_W.
- Reset mid-pattern discards partial history; the count restarts from 0.

Optional Feature:
- Macro: SEQ_DET_PROG_EN.
- Defined:
  - Adds ports pat_load (input, 1) and pat_data (input, PAT_W).
  - A posedge with pat_load = 1 stores pat_data into pat_reg and forces fill <= 0 and match <= 0.
  - When pat_load and in_valid are both high on the same edge, pat_load wins: the bit is dropped.
  - pat_reg resets to PATTERN; the active pattern is pat_reg.
- Undefined: no extra ports; the active pattern is the constant PATTERN.

Decomposition:
- Package seq_det_pkg holds:
  - Default PAT_W, PATTERN and CNT_W constants.
  - Mode encodings: OVERLAP = 1'b1, NONOVERLAP = 1'b0.
  - A fill-width function returning $clog2(PAT_W+1).
- One natural sub-module: sat_counter.
  - Parametrised by CNT_W.
  - Inputs: clk, reset, inc, clr. Output: count.
  - clr has priority over inc.
  - Reused for match_count.

Test Plan:
- PATTERN = 1011, overlap_en = 1, stream 1,0,1,1,0,1,1 (in_valid = 1 throughout): match pulses after bits 4 and 7; match_count = 2.
- Same stream with overlap_en = 0: match pulses after bit 4 only; fill = 3 at end; match_count = 1.
- Stream 1,0,(in_valid = 0 for 3 cycles),1,1: match after the final bit; match = 0 during the gap cycles; fill holds at 2 through the gap.
- CNT_W = 3, overlap_en = 1, pattern repeated 9 times with hits every edge (PATTERN = 11, stream of ones): match_count saturates at 7. Then cnt_clr asserted on a hit edge gives 0.
- Assert reset for 1 ns mid-pattern (after 1,0,1), between edges, then send 1: match_count = 0 and fill = 0 immediately; no match on that bit; fill = 1.
- With SEQ_DET_PROG_EN: load pat_data = 0110 while fill = 3, then send 0,1,1,0: match after the 4th bit. Load on the same edge as in_valid: that bit is ignored and fill = 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants, mode encodings and helpers for the serial pattern detector.
// Optional runtime-programmable pattern is enabled with SEQ_DET_PROG_EN.
package seq_det_pkg;

   localparam int DEF_PAT_W = 4;
   localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;
   localparam int DEF_CNT_W = 8;

   localparam logic OVERLAP    = 1'b1;
   localparam logic NONOVERLAP = 1'b0;

   function automatic int fill_width(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] MAX = '1;

   // Count registered hits; clear first, then saturate at MAX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with overlap/non-overlap modes.
// Define SEQ_DET_PROG_EN to load the pattern at run time (pat_load/pat_data).
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
   parameter int               CNT_W   = DEF_CNT_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic                         in_bit,
   input  logic                         overlap_en,
   input  logic                         cnt_clr,
`ifdef SEQ_DET_PROG_EN
   input  logic                         pat_load,
   input  logic [PAT_W-1:0]             pat_data,
`endif
   output logic                         match,
   output logic [CNT_W-1:0]             match_count,
   output logic [fill_width(PAT_W)-1:0] fill
);

   localparam int FW = fill_width(PAT_W);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);

   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] hist_n;
   logic [FW-1:0]    fill_n;
   logic [PAT_W-1:0] active_pat;
   logic             load;
   logic             take;
   logic             hit;

`ifdef SEQ_DET_PROG_EN
   logic [PAT_W-1:0] pat_reg;

   assign load       = pat_load;
   assign active_pat = pat_reg;

   // Programmable pattern register, back to the default on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_reg <= PATTERN;
      end else if (pat_load) begin
         pat_reg <= pat_data;
      end
   end
`else
   assign load       = 1'b0;
   assign active_pat = PATTERN;
`endif

   // A load drops any bit offered on the same edge.
   assign take = in_valid && !load;

   // Next history/fill and the completion test for the sampled bit.
   always_comb begin
      hist_n = {hist[PAT_W-2:0], in_bit};
      fill_n = (fill == FULL) ? FULL : fill + FW'(1);
      hit    = 1'b0;
      if (take && (fill_n == FULL) && (hist_n == active_pat)) begin
         hit = 1'b1;
      end
   end

   // History, fill and registered match pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist  <= '0;
         fill  <= '0;
         match <= 1'b0;
      end else if (load) begin
         fill  <= '0;
         match <= 1'b0;
      end else if (take) begin
         hist  <= hist_n;
         match <= hit;
         if (hit && (overlap_en == NONOVERLAP)) begin
            fill <= '0;
         end else begin
            fill <= fill_n;
         end
      end else begin
         match <= 1'b0;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (hit),
      .clr   (cnt_clr),
      .count (match_count)
   );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus randomized traffic
// checked against a queue-based model of the detection rules.
module tb_seq_detector_param;

   localparam int PW = 4;
   localparam int CW = 8;
   localparam int FW = $clog2(PW + 1);

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_bit = 1'b0;
   logic overlap_en = 1'b1;
   logic cnt_clr = 1'b0;
   logic pat_load = 1'b0;
   logic [PW-1:0] pat_data = '0;
   logic match;
   logic [CW-1:0] match_count;
   logic [FW-1:0] fill;

   logic s_valid = 1'b0;
   logic s_bit = 1'b0;
   logic s_clr = 1'b0;
   logic s_ov = 1'b1;
   logic s_load = 1'b0;
   logic [1:0] s_pdata = '0;
   logic s_match;
   logic [2:0] s_count;
   logic [1:0] s_fill;

   int compared = 0;
   int mismatched = 0;

   bit q[$];
   int m_count = 0;
   bit m_match = 1'b0;
   logic [PW-1:0] m_pat = 4'b1011;

   always #5 clk = ~clk;

   seq_detector_param u_dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .overlap_en  (overlap_en),
      .cnt_clr     (cnt_clr),
`ifdef SEQ_DET_PROG_EN
      .pat_load    (pat_load),
      .pat_data    (pat_data),
`endif
      .match       (match),
      .match_count (match_count),
      .fill        (fill)
   );

   seq_detector_param #(
      .PAT_W   (2),
      .PATTERN (2'b11),
      .CNT_W   (3)
   ) u_sat (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (s_valid),
      .in_bit      (s_bit),
      .overlap_en  (s_ov),
      .cnt_clr     (s_clr),
`ifdef SEQ_DET_PROG_EN
      .pat_load    (s_load),
      .pat_data    (s_pdata),
`endif
      .match       (s_match),
      .match_count (s_count),
      .fill        (s_fill)
   );

   task automatic model_reset();
      q.delete();
      m_count = 0;
      m_match = 1'b0;
      m_pat = 4'b1011;
   endtask

   task automatic model_edge(input logic v, input logic b);
      bit hit;
      hit = 1'b0;
      m_match = 1'b0;
      if (pat_load) begin
         m_pat = pat_data;
         q.delete();
      end else if (v) begin
         q.push_back(b);
         if (q.size() > PW) void'(q.pop_front());
         if (q.size() == PW) begin
            hit = 1'b1;
            for (int i = 0; i < PW; i++)
               if (q[i] != m_pat[PW-1-i]) hit = 1'b0;
         end
         m_match = hit;
         if (hit && !overlap_en) q.delete();
      end
      if (cnt_clr) m_count = 0;
      else if (hit && m_count < (1 << CW) - 1) m_count++;
   endtask

   task automatic step(input logic v, input logic b);
      in_valid = v;
      in_bit = b;
      @(posedge clk);
      model_edge(v, b);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      #3;
      compared += 3;
      if (match !== 1'b0) begin
         $display("FAIL reset_match got %b want 0", match); mismatched++;
      end
      if (match_count !== '0) begin
         $display("FAIL reset_count got %0d want 0", match_count); mismatched++;
      end
      if (fill !== '0) begin
         $display("FAIL reset_fill got %0d want 0", fill); mismatched++;
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_overlap();
      int bits[7] = '{1, 0, 1, 1, 0, 1, 1};
      int em[7] = '{0, 0, 0, 1, 0, 0, 1};
      pulse_reset();
      overlap_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step(1'b1, bits[i][0]);
         compared++;
         if (match !== em[i][0]) begin
            $display("FAIL ov_match bit%0d got %b want %0d", i + 1, match, em[i]);
            mismatched++;
         end
      end
      compared++;
      if (match_count !== 8'd2) begin
         $display("FAIL ov_count got %0d want 2", match_count); mismatched++;
      end
   endtask

   task automatic test_nonoverlap();
      int bits[7] = '{1, 0, 1, 1, 0, 1, 1};
      int em[7] = '{0, 0, 0, 1, 0, 0, 0};
      pulse_reset();
      overlap_en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step(1'b1, bits[i][0]);
         compared++;
         if (match !== em[i][0]) begin
            $display("FAIL nov_match bit%0d got %b want %0d", i + 1, match, em[i]);
            mismatched++;
         end
      end
      compared += 2;
      if (fill !== 3'd3) begin
         $display("FAIL nov_fill got %0d want 3", fill); mismatched++;
      end
      if (match_count !== 8'd1) begin
         $display("FAIL nov_count got %0d want 1", match_count); mismatched++;
      end
   endtask

   task automatic test_gap();
      int vs[7] = '{1, 1, 0, 0, 0, 1, 1};
      int bs[7] = '{1, 0, 0, 0, 0, 1, 1};
      int ef[7] = '{1, 2, 2, 2, 2, 3, 4};
      int em[7] = '{0, 0, 0, 0, 0, 0, 1};
      pulse_reset();
      overlap_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step(vs[i][0], bs[i][0]);
         compared += 2;
         if (match !== em[i][0]) begin
            $display("FAIL gap_match step%0d got %b want %0d", i, match, em[i]);
            mismatched++;
         end
         if (fill !== FW'(ef[i])) begin
            $display("FAIL gap_fill step%0d got %0d want %0d", i, fill, ef[i]);
            mismatched++;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      overlap_en = 1'b1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      compared++;
      if (match_count !== 8'd1) begin
         $display("FAIL ar_precount got %0d want 1", match_count); mismatched++;
      end
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      compared += 2;
      if (match_count !== '0) begin
         $display("FAIL ar_count got %0d want 0", match_count); mismatched++;
      end
      if (fill !== '0) begin
         $display("FAIL ar_fill got %0d want 0", fill); mismatched++;
      end
      reset = 1'b0;
      model_reset();
      step(1'b1, 1'b1);
      compared += 2;
      if (match !== 1'b0) begin
         $display("FAIL ar_match got %b want 0", match); mismatched++;
      end
      if (fill !== 3'd1) begin
         $display("FAIL ar_fill_after got %0d want 1", fill); mismatched++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_saturation();
      int want;
      s_ov = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         s_valid = 1'b1;
         s_bit = 1'b1;
         @(posedge clk);
         #1;
         want = (k - 1 > 7) ? 7 : k - 1;
         compared += 2;
         if (s_count !== 3'(want)) begin
            $display("FAIL sat_count k%0d got %0d want %0d", k, s_count, want);
            mismatched++;
         end
         if (s_match !== (k >= 2)) begin
            $display("FAIL sat_match k%0d got %b want %b", k, s_match, k >= 2);
            mismatched++;
         end
      end
      s_clr = 1'b1;
      @(posedge clk);
      #1;
      compared += 2;
      if (s_count !== 3'd0) begin
         $display("FAIL sat_clr got %0d want 0", s_count); mismatched++;
      end
      if (s_match !== 1'b1) begin
         $display("FAIL sat_clr_match got %b want 1", s_match); mismatched++;
      end
      s_clr = 1'b0;
      s_valid = 1'b0;
   endtask

   task automatic test_random();
      logic v, b;
      for (int n = 0; n < 600; n++) begin
         overlap_en = 1'($urandom_range(0, 1));
         cnt_clr = ($urandom_range(0, 31) == 0);
         v = ($urandom_range(0, 3) != 0);
         b = 1'($urandom_range(0, 1));
         step(v, b);
         compared += 3;
         if (match !== m_match) begin
            $display("FAIL rnd_match n%0d got %b want %b", n, match, m_match);
            mismatched++;
         end
         if (fill !== FW'(q.size())) begin
            $display("FAIL rnd_fill n%0d got %0d want %0d", n, fill, q.size());
            mismatched++;
         end
         if (match_count !== CW'(m_count)) begin
            $display("FAIL rnd_count n%0d got %0d want %0d", n, match_count, m_count);
            mismatched++;
         end
      end
      cnt_clr = 1'b0;
      in_valid = 1'b0;
   endtask

`ifdef SEQ_DET_PROG_EN
   task automatic test_prog();
      int bits[4] = '{0, 1, 1, 0};
      int em[4] = '{0, 0, 0, 1};
      pulse_reset();
      overlap_en = 1'b1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      pat_load = 1'b1;
      pat_data = 4'b0110;
      step(1'b0, 1'b0);
      pat_load = 1'b0;
      compared++;
      if (fill !== '0) begin
         $display("FAIL prog_fill got %0d want 0", fill); mismatched++;
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, bits[i][0]);
         compared++;
         if (match !== em[i][0]) begin
            $display("FAIL prog_match bit%0d got %b want %0d", i + 1, match, em[i]);
            mismatched++;
         end
      end
      pat_load = 1'b1;
      step(1'b1, 1'b1);
      pat_load = 1'b0;
      compared += 2;
      if (fill !== '0) begin
         $display("FAIL prog_drop_fill got %0d want 0", fill); mismatched++;
      end
      if (match !== 1'b0) begin
         $display("FAIL prog_drop_match got %b want 0", match); mismatched++;
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, bits[i][0]);
         compared++;
         if (match !== em[i][0]) begin
            $display("FAIL prog_after bit%0d got %b want %0d", i + 1, match, em[i]);
            mismatched++;
         end
      end
      in_valid = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_gap();
      test_async_reset();
      test_saturation();
      test_random();
`ifdef SEQ_DET_PROG_EN
      test_prog();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
